// File: rtl/bullet_collision_pkg.sv
// Shared game types for the bullet-hell combat screen: colors, box fields, FSM encoding.
package bullet_collision_pkg;

  localparam int unsigned COORD_W = 8;
  localparam int unsigned SUM_W   = COORD_W + 1;
  localparam int unsigned BOX_W   = 2 * COORD_W;
  localparam int unsigned COLOR_W = 3;
  localparam int unsigned HP_W    = 8;
  localparam int unsigned CNT_W   = 8;

  localparam logic [COLOR_W-1:0] COLOR_WHITE = 3'b000;
  localparam logic [COLOR_W-1:0] COLOR_GREEN = 3'b001;
  localparam logic [COLOR_W-1:0] COLOR_BLUE  = 3'b010;

  // Position is {x, y}; size is {w, h}; both use the same field split.
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } xy_t;

  typedef struct packed {
    logic [BOX_W-1:0]   pos;
    logic [BOX_W-1:0]   size;
    logic [COLOR_W-1:0] color;
    logic               render;
  } bullet_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHECK1  = 2'd1,
    CHECK2  = 2'd2,
    RESOLVE = 2'd3
  } state_e;

endpackage

// File: rtl/box_overlap.sv
// Combinational axis-aligned box overlap; end coordinates carry a ninth bit so nothing wraps at 255.
module box_overlap
  import bullet_collision_pkg::*;
(
  input  logic [BOX_W-1:0] a_pos_i,
  input  logic [BOX_W-1:0] a_size_i,
  input  logic [BOX_W-1:0] b_pos_i,
  input  logic [BOX_W-1:0] b_size_i,
  output logic             hit_c_o
);

  xy_t              a_pos, a_size, b_pos, b_size;
  logic [SUM_W-1:0] a_x_end, a_y_end, b_x_end, b_y_end;
  logic             nonzero, x_ovl, y_ovl;

  assign a_pos  = xy_t'(a_pos_i);
  assign a_size = xy_t'(a_size_i);
  assign b_pos  = xy_t'(b_pos_i);
  assign b_size = xy_t'(b_size_i);

  assign a_x_end = SUM_W'(a_pos.x) + SUM_W'(a_size.x);
  assign a_y_end = SUM_W'(a_pos.y) + SUM_W'(a_size.y);
  assign b_x_end = SUM_W'(b_pos.x) + SUM_W'(b_size.x);
  assign b_y_end = SUM_W'(b_pos.y) + SUM_W'(b_size.y);

  assign nonzero = (a_size.x != '0) && (a_size.y != '0) &&
                   (b_size.x != '0) && (b_size.y != '0);
  assign x_ovl   = (SUM_W'(a_pos.x) < b_x_end) && (SUM_W'(b_pos.x) < a_x_end);
  assign y_ovl   = (SUM_W'(a_pos.y) < b_y_end) && (SUM_W'(b_pos.y) < a_y_end);

  assign hit_c_o = nonzero && x_ovl && y_ovl;

endmodule

// File: rtl/bullet_collision.sv
// Per-frame collision resolver: snapshots two bullets and the heart, tests each in turn,
// then applies damage/heal, the invulnerability window and the one-cycle isCollide pulse.
module bullet_collision
  import bullet_collision_pkg::*;
#(
  parameter int unsigned MAX_HP        = 20,
  parameter int unsigned DAMAGE        = 4,
  parameter int unsigned HEAL          = 2,
  parameter int unsigned INVULN_FRAMES = 30
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frameTick,
  input  logic [BOX_W-1:0]   position1,
  input  logic [BOX_W-1:0]   position2,
  input  logic [BOX_W-1:0]   size1,
  input  logic [BOX_W-1:0]   size2,
  input  logic [COLOR_W-1:0] color1,
  input  logic [COLOR_W-1:0] color2,
  input  logic               isRender1,
  input  logic               isRender2,
  input  logic [BOX_W-1:0]   heartPos,
  input  logic [BOX_W-1:0]   heartSize,
  input  logic               heartMoving,
  output logic               isCollide,
  output logic [1:0]         hitMask,
  output logic [HP_W-1:0]    hp,
  output logic               invuln,
  output logic               isDead
);

  state_e           state_q, state_d;
  bullet_t          b1_q, b2_q, cur_b;
  logic [BOX_W-1:0] heart_pos_q, heart_size_q;
  logic             moving_q;
  logic [1:0]       dmg_q, dmg_d, grn_q, grn_d, mask_q, mask_d;
  logic [HP_W-1:0]  hp_q, hp_d, hp_after_dmg;
  logic [HP_W:0]    hp_heal_sum;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dead_q, dead_d, collide_q, collide_d;
  logic             overlap_c, qual_c, cur_dmg_c, cur_grn_c, invuln_c;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      b1_q         <= '0;
      b2_q         <= '0;
      heart_pos_q  <= '0;
      heart_size_q <= '0;
      moving_q     <= 1'b0;
      dmg_q        <= '0;
      grn_q        <= '0;
      mask_q       <= '0;
      hp_q         <= HP_W'(MAX_HP);
      cnt_q        <= '0;
      dead_q       <= 1'b0;
      collide_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dmg_q     <= dmg_d;
      grn_q     <= grn_d;
      mask_q    <= mask_d;
      hp_q      <= hp_d;
      cnt_q     <= cnt_d;
      dead_q    <= dead_d;
      collide_q <= collide_d;
      if (state_q == IDLE && frameTick) begin
        b1_q         <= '{pos: position1, size: size1, color: color1, render: isRender1};
        b2_q         <= '{pos: position2, size: size2, color: color2, render: isRender2};
        heart_pos_q  <= heartPos;
        heart_size_q <= heartSize;
        moving_q     <= heartMoving;
      end
    end
  end

  // Next-state: ticks outside IDLE are simply dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frameTick) state_d = CHECK1;
      CHECK1:  state_d = CHECK2;
      CHECK2:  state_d = RESOLVE;
      RESOLVE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One overlap unit time-shared between the two bullet slots.
  assign cur_b = (state_q == CHECK2) ? b2_q : b1_q;

  box_overlap u_overlap (
    .a_pos_i  (cur_b.pos),
    .a_size_i (cur_b.size),
    .b_pos_i  (heart_pos_q),
    .b_size_i (heart_size_q),
    .hit_c_o  (overlap_c)
  );

  // Unknown color codes fall through to the white (damaging) class.
  assign qual_c    = cur_b.render && overlap_c;
  assign cur_grn_c = qual_c && (cur_b.color == COLOR_GREEN);
  assign cur_dmg_c = qual_c && (cur_b.color != COLOR_GREEN) &&
                     ((cur_b.color != COLOR_BLUE) || moving_q);
  assign invuln_c  = (cnt_q != '0);

  // Output/datapath next values; damage resolves before heal within a frame.
  always_comb begin
    dmg_d        = dmg_q;
    grn_d        = grn_q;
    hp_d         = hp_q;
    cnt_d        = cnt_q;
    dead_d       = dead_q;
    collide_d    = 1'b0;
    mask_d       = '0;
    hp_after_dmg = hp_q;
    hp_heal_sum  = '0;
    if (frameTick && invuln_c) cnt_d = cnt_q - CNT_W'(1);
    case (state_q)
      CHECK1: begin
        dmg_d[0] = cur_dmg_c;
        grn_d[0] = cur_grn_c;
      end
      CHECK2: begin
        dmg_d[1] = cur_dmg_c;
        grn_d[1] = cur_grn_c;
      end
      RESOLVE: begin
        if (!dead_q) begin
          if ((|dmg_q) && !invuln_c) begin
            hp_after_dmg = (hp_q > HP_W'(DAMAGE)) ? hp_q - HP_W'(DAMAGE) : '0;
            cnt_d        = CNT_W'(INVULN_FRAMES);
            mask_d       = dmg_q;
          end
          hp_d = hp_after_dmg;
          if (|grn_q) begin
            hp_heal_sum = (HP_W+1)'(hp_after_dmg) + (HP_W+1)'(HEAL);
            hp_d        = (hp_heal_sum > (HP_W+1)'(MAX_HP)) ? HP_W'(MAX_HP)
                                                            : HP_W'(hp_heal_sum);
            mask_d      = mask_d | grn_q;
          end
          collide_d = |mask_d;
          dead_d    = (hp_d == '0);
        end
      end
      default: ;
    endcase
  end

  assign isCollide = collide_q;
  assign hitMask   = mask_q;
  assign hp        = hp_q;
  assign invuln    = invuln_c;
  assign isDead    = dead_q;

endmodule
